// File: rtl/ram_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_loader_pkg / ram_loader_if
//  Purpose  : Shared memory-op / access-width types and the bundled bus
//             between the byte-stream source, the rv32i core port and the
//             RAM port of ram_loader.
//  Contents : byte stream  : byte_valid, byte_data, byte_last, byte_ready
//             core side    : cpu_addr, cpu_wdata, cpu_mem_op, cpu_ram_mask,
//                            cpu_rdata
//             RAM side     : ram_addr, ram_wdata, ram_mem_op, ram_ram_mask,
//                            ram_rdata
//  Modports : slave  - the loader (drives byte_ready, cpu_rdata, ram_*)
//             master - the surrounding system (drives everything else)
//  Revision : 1.0 - initial release
// ============================================================================
package ram_loader_pkg;
    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        RAM_MASK_B = 2'd0,
        RAM_MASK_H = 2'd1,
        RAM_MASK_W = 2'd2
    } ram_mask_e;
endpackage

interface ram_loader_if;
    import ram_loader_pkg::*;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;

    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    mem_op_e     cpu_mem_op;
    ram_mask_e   cpu_ram_mask;
    logic [31:0] cpu_rdata;

    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    mem_op_e     ram_mem_op;
    ram_mask_e   ram_ram_mask;
    logic [31:0] ram_rdata;

    modport slave (
        input  byte_valid, byte_data, byte_last,
        output byte_ready,
        input  cpu_addr, cpu_wdata, cpu_mem_op, cpu_ram_mask,
        output cpu_rdata,
        output ram_addr, ram_wdata, ram_mem_op, ram_ram_mask,
        input  ram_rdata
    );

    modport master (
        output byte_valid, byte_data, byte_last,
        input  byte_ready,
        output cpu_addr, cpu_wdata, cpu_mem_op, cpu_ram_mask,
        input  cpu_rdata,
        input  ram_addr, ram_wdata, ram_mem_op, ram_ram_mask,
        output ram_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ram_loader
//  Purpose  : Boot-time program loader in front of the instruction/data RAM.
//             Packs a byte stream into little-endian 32-bit words, stores
//             them to RAM while holding the core in reset, then hands the
//             RAM port to the core as a combinational pass-through.
//  Ports    : clk, rst_n (async, active-low)
//             start      - 1-cycle pulse, begins a new load (IDLE/RUN only)
//             bus        - ram_loader_if.slave (byte stream, core, RAM)
//             cpu_rst_n  - registered core reset, low while loading
//             busy       - load in progress
//             done       - sticky, last load completed
//             load_bytes - bytes accepted in current/last load (wraps)
//             checksum   - only with LOADER_CHECKSUM_EN: mod-2^32 byte sum
//  Config   : `define LOADER_CHECKSUM_EN adds the checksum port and adder.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int          ADDR_LENGTH = 21,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    ram_loader_if.slave            bus,
    output logic                   cpu_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_LENGTH-1:0] load_bytes
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]            checksum
`endif
);

    localparam logic [31:0] c_ADDR_MASK = (ADDR_LENGTH >= 32) ? 32'hFFFF_FFFF
                                        : ((32'd1 << ADDR_LENGTH) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_RUN     = 2'd3
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [ADDR_LENGTH-1:0] r_word_ptr;
    logic [1:0]             r_lane;
    logic [31:0]            r_pack;
    logic [ADDR_LENGTH-1:0] r_load_bytes;
    logic                   r_last_seen;
    logic                   r_done;
    logic                   r_cpu_rst_n;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]            r_checksum;
`endif

    logic                   w_accept;
    logic                   w_enter_collect;
    logic [31:0]            w_write_addr;

    assign w_accept        = (r_state == S_COLLECT) && bus.byte_valid;
    assign w_enter_collect = start && ((r_state == S_IDLE) || (r_state == S_RUN));
    // Word pointer is already modulo 2^ADDR_LENGTH; the mask folds in the base.
    assign w_write_addr    = (BASE_ADDR + (32'(r_word_ptr) << 2)) & c_ADDR_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_next = S_COLLECT;
            S_COLLECT: if (w_accept && ((r_lane == 2'd3) || bus.byte_last))
                           w_state_next = S_WRITE;
            S_WRITE:   w_state_next = r_last_seen ? S_RUN : S_COLLECT;
            S_RUN:     if (start) w_state_next = S_COLLECT;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_ptr   <= '0;
            r_lane       <= 2'd0;
            r_pack       <= 32'd0;
            r_load_bytes <= '0;
            r_last_seen  <= 1'b0;
            r_done       <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum   <= 32'd0;
`endif
        end else if (w_enter_collect) begin
            r_word_ptr   <= '0;
            r_lane       <= 2'd0;
            r_pack       <= 32'd0;
            r_load_bytes <= '0;
            r_last_seen  <= 1'b0;
            r_done       <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum   <= 32'd0;
`endif
        end else if (w_accept) begin
            r_pack[{r_lane, 3'b000} +: 8] <= bus.byte_data;
            r_lane       <= r_lane + 2'd1;
            r_load_bytes <= r_load_bytes + ADDR_LENGTH'(1);
            if (bus.byte_last) begin
                r_last_seen <= 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            r_checksum   <= r_checksum + {24'd0, bus.byte_data};
`endif
        end else if (r_state == S_WRITE) begin
            // Pack is cleared after each store so a short final word
            // carries zeros in its unfilled upper lanes.
            r_word_ptr <= r_word_ptr + ADDR_LENGTH'(1);
            r_lane     <= 2'd0;
            r_pack     <= 32'd0;
            if (r_last_seen) begin
                r_done      <= 1'b1;
                r_cpu_rst_n <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.byte_ready   = 1'b0;
        bus.ram_addr     = 32'd0;
        bus.ram_wdata    = 32'd0;
        bus.ram_mem_op   = MEM_LOAD;
        bus.ram_ram_mask = RAM_MASK_W;
        case (r_state)
            S_COLLECT: bus.byte_ready = 1'b1;
            S_WRITE: begin
                bus.ram_addr   = w_write_addr;
                bus.ram_wdata  = r_pack;
                bus.ram_mem_op = MEM_STORE;
            end
            S_RUN: begin
                bus.ram_addr     = bus.cpu_addr;
                bus.ram_wdata    = bus.cpu_wdata;
                bus.ram_mem_op   = bus.cpu_mem_op;
                bus.ram_ram_mask = bus.cpu_ram_mask;
            end
            default: ;
        endcase
    end

    assign bus.cpu_rdata = bus.ram_rdata;
    assign busy          = (r_state == S_COLLECT) || (r_state == S_WRITE);
    assign done          = r_done;
    assign cpu_rst_n     = r_cpu_rst_n;
    assign load_bytes    = r_load_bytes;
`ifdef LOADER_CHECKSUM_EN
    assign checksum      = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_loader
//  Purpose  : Self-checking bench for ram_loader. Two instances share one
//             stimulus: default parameters, and ADDR_LENGTH=4 / BASE_ADDR=12
//             to exercise address wrap. A word-level model (list of accepted
//             bytes, count of stores issued) predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_loader;
    import ram_loader_pkg::*;

    localparam int          A_AL   = 21;
    localparam logic [31:0] A_BASE = 32'h0;
    localparam int          W_AL   = 4;
    localparam logic [31:0] W_BASE = 32'd12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    logic            cpu_rst_n_a, busy_a, done_a;
    logic [A_AL-1:0] load_bytes_a;
    logic            cpu_rst_n_w, busy_w, done_w;
    logic [W_AL-1:0] load_bytes_w;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]     checksum_a, checksum_w;
`endif

    ram_loader_if bus_a();
    ram_loader_if bus_w();

    assign bus_w.byte_valid   = bus_a.byte_valid;
    assign bus_w.byte_data    = bus_a.byte_data;
    assign bus_w.byte_last    = bus_a.byte_last;
    assign bus_w.cpu_addr     = bus_a.cpu_addr;
    assign bus_w.cpu_wdata    = bus_a.cpu_wdata;
    assign bus_w.cpu_mem_op   = bus_a.cpu_mem_op;
    assign bus_w.cpu_ram_mask = bus_a.cpu_ram_mask;
    assign bus_w.ram_rdata    = bus_a.ram_rdata;

    ram_loader #(.ADDR_LENGTH(A_AL), .BASE_ADDR(A_BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_a),
        .cpu_rst_n(cpu_rst_n_a), .busy(busy_a), .done(done_a),
        .load_bytes(load_bytes_a)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum_a)
`endif
    );

    ram_loader #(.ADDR_LENGTH(W_AL), .BASE_ADDR(W_BASE)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_w),
        .cpu_rst_n(cpu_rst_n_w), .busy(busy_w), .done(done_w),
        .load_bytes(load_bytes_w)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum_w)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_loading = 0;
    bit          m_running = 0;
    bit          m_last    = 0;
    int          m_stores  = 0;
    logic [7:0]  m_q[$];
    int          busy_cycles = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] log_waddr[$];
    bit          cpu_rand_en = 1;

    function automatic int words_formed();
        return m_q.size() / 4 + ((m_last && (m_q.size() % 4 != 0)) ? 1 : 0);
    endfunction

    function automatic logic [31:0] byte_sum();
        logic [31:0] s = 32'd0;
        foreach (m_q[i]) s = s + {24'd0, m_q[i]};
        return s;
    endfunction

    always @(negedge clk) begin
        bit          store_now;
        logic [31:0] wexp;
        logic [31:0] aexp, wadexp;
        int          k;
        chk("cpu_rdata_a", bus_a.cpu_rdata, bus_a.ram_rdata);
        chk("cpu_rdata_w", bus_w.cpu_rdata, bus_w.ram_rdata);
        if (!rst_n) begin
            m_loading = 0; m_running = 0; m_last = 0; m_stores = 0; m_q.delete();
            chk("rst_busy",  {busy_a, busy_w}, 2'b00);
            chk("rst_ready", {bus_a.byte_ready, bus_w.byte_ready}, 2'b00);
            chk("rst_done",  {done_a, done_w}, 2'b00);
            chk("rst_cpurst", {cpu_rst_n_a, cpu_rst_n_w}, 2'b00);
            chk("rst_lbytes_a", load_bytes_a, 0);
            chk("rst_lbytes_w", load_bytes_w, 0);
`ifdef LOADER_CHECKSUM_EN
            chk("rst_csum", {checksum_a, checksum_w}, 64'd0);
`endif
        end else begin
            store_now = m_loading && (words_formed() > m_stores);
            if (busy_a) busy_cycles++;
            chk("busy_a",  busy_a, m_loading);
            chk("busy_w",  busy_w, m_loading);
            chk("ready_a", bus_a.byte_ready, m_loading && !store_now);
            chk("ready_w", bus_w.byte_ready, m_loading && !store_now);
            chk("done_a",  done_a, m_running);
            chk("done_w",  done_w, m_running);
            chk("cpurst_a", cpu_rst_n_a, m_running);
            chk("cpurst_w", cpu_rst_n_w, m_running);
            chk("lbytes_a", load_bytes_a, 64'(m_q.size() % (1 << A_AL)));
            chk("lbytes_w", load_bytes_w, 64'(m_q.size() % (1 << W_AL)));
`ifdef LOADER_CHECKSUM_EN
            chk("csum_a", checksum_a, byte_sum());
            chk("csum_w", checksum_w, byte_sum());
`endif
            if (store_now) begin
                k = m_stores;
                wexp = 32'd0;
                for (int j = 0; j < 4; j++)
                    if (4 * k + j < m_q.size()) wexp[8*j +: 8] = m_q[4*k + j];
                aexp   = (A_BASE + 32'(4 * k)) % (32'd1 << A_AL);
                wadexp = (W_BASE + 32'(4 * k)) % (32'd1 << W_AL);
                chk("st_op_a",   bus_a.ram_mem_op, MEM_STORE);
                chk("st_mask_a", bus_a.ram_ram_mask, RAM_MASK_W);
                chk("st_addr_a", bus_a.ram_addr, aexp);
                chk("st_data_a", bus_a.ram_wdata, wexp);
                chk("st_op_w",   bus_w.ram_mem_op, MEM_STORE);
                chk("st_addr_w", bus_w.ram_addr, wadexp);
                chk("st_data_w", bus_w.ram_wdata, wexp);
            end else if (m_loading) begin
                chk("ld_op_a",   bus_a.ram_mem_op, MEM_LOAD);
                chk("ld_mask_a", bus_a.ram_ram_mask, RAM_MASK_W);
                chk("ld_addr_a", bus_a.ram_addr, 0);
                chk("ld_data_a", bus_a.ram_wdata, 0);
                chk("ld_op_w",   bus_w.ram_mem_op, MEM_LOAD);
            end else if (m_running) begin
                chk("pt_addr_a", bus_a.ram_addr, bus_a.cpu_addr);
                chk("pt_data_a", bus_a.ram_wdata, bus_a.cpu_wdata);
                chk("pt_op_a",   bus_a.ram_mem_op, bus_a.cpu_mem_op);
                chk("pt_mask_a", bus_a.ram_ram_mask, bus_a.cpu_ram_mask);
                chk("pt_addr_w", bus_w.ram_addr, bus_w.cpu_addr);
                chk("pt_op_w",   bus_w.ram_mem_op, bus_w.cpu_mem_op);
            end
            if (bus_a.ram_mem_op == MEM_STORE && busy_a) begin
                log_addr.push_back(bus_a.ram_addr);
                log_data.push_back(bus_a.ram_wdata);
                log_waddr.push_back(bus_w.ram_addr);
            end
            // Advance the model to what the next edge produces.
            if (!m_loading && start) begin
                m_loading = 1; m_running = 0; m_last = 0; m_stores = 0; m_q.delete();
            end else if (m_loading) begin
                if (store_now) begin
                    m_stores++;
                    if (m_last && m_stores == words_formed()) begin
                        m_loading = 0; m_running = 1;
                    end
                end else if (bus_a.byte_valid) begin
                    m_q.push_back(bus_a.byte_data);
                    if (bus_a.byte_last) m_last = 1;
                end
            end
        end
    end

    // Background randomisation of the core-side request and RAM read data.
    always @(posedge clk) begin
        #1;
        bus_a.ram_rdata = $urandom;
        if (cpu_rand_en) begin
            bus_a.cpu_addr     = $urandom;
            bus_a.cpu_wdata    = $urandom;
            bus_a.cpu_mem_op   = mem_op_e'($urandom_range(0, 2));
            bus_a.cpu_ram_mask = ram_mask_e'($urandom_range(0, 2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] d[$], input bit with_last, input bit gaps);
        bit acc;
        int guard;
        for (int i = 0; i < d.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus_a.byte_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            bus_a.byte_valid = 1'b1;
            bus_a.byte_data  = d[i];
            bus_a.byte_last  = with_last && (i == d.size() - 1);
            // A stray start while loading must be ignored.
            start = gaps && ($urandom_range(0, 5) == 0);
            acc = 0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = bus_a.byte_ready;
                @(posedge clk); #1;
                start = 1'b0;
                guard++;
                if (!acc && guard > 20) begin
                    total++; bad++;
                    $display("FAIL accept_timeout actual=no_ready required=ready_within_20");
                    acc = 1;
                end
            end
        end
        bus_a.byte_valid = 1'b0;
        bus_a.byte_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            seen = done_a;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_waddr.delete();
    endtask

    initial begin
        logic [7:0] d[$];
        bus_a.byte_valid = 1'b0; bus_a.byte_data = 8'h00; bus_a.byte_last = 1'b0;
        bus_a.cpu_addr = 32'd0; bus_a.cpu_wdata = 32'd0;
        bus_a.cpu_mem_op = MEM_NOP; bus_a.cpu_ram_mask = RAM_MASK_W;
        bus_a.ram_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy_a, 1'b0);
        chk("post_rst_cpurst", cpu_rst_n_a, 1'b0);
        @(posedge clk); #1;

        // 8 bytes 01..08
        clear_log();
        d.delete();
        for (int i = 1; i <= 8; i++) d.push_back(8'(i));
        pulse_start();
        send_bytes(d, 1, 0);
        wait_done();
        chk("t1_nstores", log_addr.size(), 2);
        chk("t1_addr0", log_addr[0], 32'h0);
        chk("t1_data0", log_data[0], 32'h04030201);
        chk("t1_addr1", log_addr[1], 32'h4);
        chk("t1_data1", log_data[1], 32'h08070605);
        chk("t1_waddr0", log_waddr[0], 32'd12);
        chk("t1_waddr1", log_waddr[1], 32'd0);
        chk("t1_done", done_a, 1'b1);
        chk("t1_cpurst", cpu_rst_n_a, 1'b1);
        chk("t1_lbytes", load_bytes_a, 8);
`ifdef LOADER_CHECKSUM_EN
        chk("t1_csum", checksum_a, 32'h24);
`endif

        // Pass-through in RUN, then restart drops the core reset.
        cpu_rand_en = 0;
        @(posedge clk); #1;
        bus_a.cpu_addr = 32'h40; bus_a.cpu_mem_op = MEM_STORE;
        bus_a.cpu_wdata = 32'hCAFE_F00D; bus_a.cpu_ram_mask = RAM_MASK_W;
        @(negedge clk);
        chk("pt_addr_lit", bus_a.ram_addr, 32'h40);
        chk("pt_op_lit", bus_a.ram_mem_op, MEM_STORE);
        chk("pt_data_lit", bus_a.ram_wdata, 32'hCAFE_F00D);
        @(posedge clk); #1;
        cpu_rand_en = 1;
        pulse_start();
        @(negedge clk);
        chk("restart_cpurst", cpu_rst_n_a, 1'b0);
        chk("restart_done", done_a, 1'b0);

        // 5 bytes, partial final word (already in COLLECT)
        clear_log();
        @(posedge clk); #1;
        d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_bytes(d, 1, 0);
        wait_done();
        chk("t2_nstores", log_addr.size(), 2);
        chk("t2_data0", log_data[0], 32'hDDCCBBAA);
        chk("t2_data1", log_data[1], 32'h000000EE);

        // 12 bytes with byte_valid held high: 15 busy cycles
        clear_log();
        d.delete();
        for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
        pulse_start();
        busy_cycles = 0;
        send_bytes(d, 1, 0);
        wait_done();
        chk("t3_busy_cycles", busy_cycles, 15);
        chk("t3_nstores", log_addr.size(), 3);

        // Reset mid-load after 6 bytes, then a 4-byte load
        d.delete();
        for (int i = 0; i < 6; i++) d.push_back(8'($urandom));
        pulse_start();
        send_bytes(d, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_busy", busy_a, 1'b0);
        chk("t4_lbytes", load_bytes_a, 0);
        chk("t4_ready", bus_a.byte_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_log();
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start();
        send_bytes(d, 1, 0);
        wait_done();
        chk("t4_nstores", log_addr.size(), 1);
        chk("t4_addr", log_addr[0], 32'h0);
        chk("t4_data", log_data[0], 32'h44332211);

        // Randomised loads with gaps and stray start pulses
        for (int n = 0; n < 25; n++) begin
            d.delete();
            for (int i = 0; i < $urandom_range(1, 40); i++) d.push_back(8'($urandom));
            pulse_start();
            send_bytes(d, 1, 1);
            wait_done();
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
